// File: rtl/geofence_feeder.sv
// ---------------------------------------------------------------------------
// geofence_feeder
//
// Upstream stage of the geofence detector. Buffers producer points in a FIFO
// and replays them as 7-point sets (object point, then six fence vertices) on
// X/Y at the detector's fixed sampling cadence. The detector cannot stall, so
// the feeder tracks the detector phase itself:
//   BOOT : mirrors the detector's idle cycle after reset
//   SEND : 7 cycles, k = 0..6, one point per cycle
//   WAIT : until the detector strobes gf_valid with its result
// A window is only committed when all 7 points are already buffered at the
// edge that opens it; otherwise X/Y are driven with 0 for that window and the
// sticky underrun flag is raised.
//
// Parameters:
//   DEPTH     FIFO capacity in points (power of two, >= 14)
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-high
//   in_valid  in   producer offers a point
//   in_x      in   [9:0] point X coordinate
//   in_y      in   [9:0] point Y coordinate
//   in_ready  out  FIFO can accept (count < DEPTH)
//   gf_valid  in   detector result strobe (one cycle)
//   X         out  [9:0] registered coordinate to detector
//   Y         out  [9:0] registered coordinate to detector
//   set_done  out  one-cycle pulse after the 7th point of a committed set
//   underrun  out  sticky: a window opened with fewer than 7 points buffered
// ---------------------------------------------------------------------------
module geofence_feeder #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    output logic       in_ready,
    input  logic       gf_valid,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       set_done,
    output logic       underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SET_LEN = CW'(7);
    localparam logic [2:0]    LAST_K  = 3'd6;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t        state;
    logic [2:0]    k;
    logic          committed;

    logic [9:0]    mem_x [DEPTH];
    logic [9:0]    mem_y [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          open_window;
    logic          commit_now;

    // in_ready looks only at the registered count, so a pop at the same edge
    // never lets an extra point in.
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid && in_ready;

    // NOTE: every signal driven here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        open_window = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_BOOT: open_window = 1'b1;
            ST_WAIT: open_window = gf_valid;
            ST_SEND: pop = committed && (k != LAST_K);
            default: ;
        endcase
        // Commit decision uses the count before this edge's push.
        commit_now = open_window && (count >= SET_LEN);
        if (commit_now) begin
            pop = 1'b1;
        end
    end

    // NOTE: the point storage has no reset; emptying the FIFO only needs the
    // pointers and count cleared, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
        end
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // right-hand side sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_BOOT;
            k         <= 3'd0;
            committed <= 1'b0;
            X         <= 10'd0;
            Y         <= 10'd0;
            set_done  <= 1'b0;
            underrun  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            set_done <= 1'b0;

            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            case (state)
                ST_BOOT, ST_WAIT: begin
                    if (open_window) begin
                        state     <= ST_SEND;
                        k         <= 3'd0;
                        committed <= commit_now;
                        if (!commit_now) begin
                            underrun <= 1'b1;
                        end
                        X <= commit_now ? mem_x[rd_ptr] : 10'd0;
                        Y <= commit_now ? mem_y[rd_ptr] : 10'd0;
                    end
                end
                ST_SEND: begin
                    if (k == LAST_K) begin
                        state    <= ST_WAIT;
                        set_done <= committed;
                    end else begin
                        k <= k + 3'd1;
                        // Inside a SEND window pop == committed.
                        X <= pop ? mem_x[rd_ptr] : 10'd0;
                        Y <= pop ? mem_y[rd_ptr] : 10'd0;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_feeder.sv
// ---------------------------------------------------------------------------
// tb_geofence_feeder
//
// Self-checking bench for geofence_feeder. A hand-built vector table covers
// the boot underrun and first committed set; short hand-written sequences
// cover the multi-cycle corners; a randomized run is checked cycle by cycle
// against a queue-based reference model of the feeder's rules.
// ---------------------------------------------------------------------------
module tb_geofence_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic       in_ready;
    logic       gf_valid;
    logic [9:0] X;
    logic [9:0] Y;
    logic       set_done;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } pt_t;

    typedef struct {
        bit         iv;
        logic [9:0] x;
        logic [9:0] y;
        bit         gv;
        logic [9:0] ex;
        logic [9:0] ey;
        bit         edone;
        bit         eund;
        bit         erdy;
    } vec_t;

    // Reference model: buffered points as a queue, plus where the detector is
    // in its cycle (-1 idle after reset, 0..6 point slot, 7 awaiting result).
    pt_t        mq[$];
    int         m_phase;
    bit         m_commit;
    bit         m_done;
    bit         m_under;
    logic [9:0] m_x;
    logic [9:0] m_y;

    int done_seen;
    int p_idx;
    int p_total;
    int p_base;

    always #5 clk = ~clk;

    geofence_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_ready (in_ready),
        .gf_valid (gf_valid),
        .X        (X),
        .Y        (Y),
        .set_done (set_done),
        .underrun (underrun)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase  = -1;
        m_commit = 1'b0;
        m_done   = 1'b0;
        m_under  = 1'b0;
        m_x      = 10'd0;
        m_y      = 10'd0;
    endtask

    task automatic model_emit();
        pt_t h;
        if (m_commit) begin
            h   = mq.pop_front();
            m_x = h.x;
            m_y = h.y;
        end else begin
            m_x = 10'd0;
            m_y = 10'd0;
        end
    endtask

    // One clock edge of the model; take says whether the offered point is
    // accepted (decided from the occupancy before the edge).
    task automatic model_step(input bit take, input pt_t p, input bit gv);
        m_done = 1'b0;
        if (m_phase == -1 || (m_phase == 7 && gv)) begin
            m_commit = (mq.size() >= 7);
            if (!m_commit) m_under = 1'b1;
            m_phase = 0;
            model_emit();
        end else if (m_phase >= 0 && m_phase < 6) begin
            m_phase++;
            model_emit();
        end else if (m_phase == 6) begin
            m_phase = 7;
            m_done  = m_commit;
        end
        if (take) mq.push_back(p);
    endtask

    // Drive one cycle of inputs, advance model and DUT by one edge, compare.
    task automatic cycle(input bit iv, input pt_t p, input bit gv, output bit acc);
        in_valid = iv;
        in_x     = p.x;
        in_y     = p.y;
        gf_valid = gv;
        acc      = iv && (mq.size() < DEPTH);
        model_step(acc, p, gv);
        @(posedge clk);
        #1;
        if (set_done) done_seen++;
        check("X", int'(X), int'(m_x));
        check("Y", int'(Y), int'(m_y));
        check("set_done", int'(set_done), int'(m_done));
        check("underrun", int'(underrun), int'(m_under));
        check("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
    endtask

    // Producer that holds its current point until accepted.
    task automatic prod(input bit gv);
        pt_t        p;
        bit         acc;
        logic [9:0] v;
        v   = 10'(p_base + p_idx);
        p.x = v;
        p.y = ~v;
        cycle(p_idx < p_total, p, gv, acc);
        if (acc) p_idx++;
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        gf_valid = 1'b0;
        in_x     = 10'd0;
        in_y     = 10'd0;
        reset    = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_X", int'(X), 0);
        check("rst_Y", int'(Y), 0);
        check("rst_set_done", int'(set_done), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
    endtask

    vec_t tbl[18];

    initial begin
        // Boot with no data: underrun window while 7 points arrive, then the
        // first committed set P0..P6 after gf_valid.
        for (int i = 0; i < 18; i++) begin
            tbl[i] = '{iv: 1'b0, x: 10'd0, y: 10'd0, gv: 1'b0, ex: 10'd0, ey: 10'd0,
                       edone: 1'b0, eund: 1'b1, erdy: 1'b1};
        end
        for (int i = 0; i < 7; i++) begin
            tbl[i].iv = 1'b1;
            tbl[i].x  = 10'(100 + i);
            tbl[i].y  = 10'(200 + i);
        end
        tbl[9].gv = 1'b1;
        for (int i = 9; i < 16; i++) begin
            tbl[i].ex = 10'(100 + i - 9);
            tbl[i].ey = 10'(200 + i - 9);
        end
        tbl[16].ex = 10'd106; tbl[16].ey = 10'd206; tbl[16].edone = 1'b1;
        tbl[17].ex = 10'd106; tbl[17].ey = 10'd206;

        done_seen = 0;
        p_idx     = 0;
        p_total   = 0;
        p_base    = 0;

        reset_dut();

        for (int i = 0; i < 18; i++) begin
            pt_t p;
            bit  acc;
            p.x = tbl[i].x;
            p.y = tbl[i].y;
            cycle(tbl[i].iv, p, tbl[i].gv, acc);
            check($sformatf("tbl%0d_X", i), int'(X), int'(tbl[i].ex));
            check($sformatf("tbl%0d_Y", i), int'(Y), int'(tbl[i].ey));
            check($sformatf("tbl%0d_done", i), int'(set_done), int'(tbl[i].edone));
            check($sformatf("tbl%0d_under", i), int'(underrun), int'(tbl[i].eund));
            check($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].erdy));
        end

        // gf_valid during SEND(3) must not restart the window.
        p_base = 300; p_idx = 0; p_total = 7;
        for (int i = 0; i < 7; i++) prod(1'b0);
        prod(1'b1);
        check("gv_send0_X", int'(X), 300);
        for (int i = 0; i < 3; i++) prod(1'b0);
        prod(1'b1);
        check("gv_ignored_k4_X", int'(X), 304);
        done_seen = 0;
        for (int i = 0; i < 3; i++) prod(1'b0);
        check("gv_ignored_done", done_seen, 1);

        // Backpressure: 20 points offered while waiting, FIFO holds 16.
        p_base = 400; p_idx = 0; p_total = 20;
        for (int i = 0; i < 18; i++) prod(1'b0);
        check("bp_accepted16", p_idx, 16);
        check("bp_ready_low", int'(in_ready), 0);
        prod(1'b1);
        check("bp_refused_at_open", p_idx, 16);
        check("bp_first_X", int'(X), 400);
        prod(1'b0);
        check("bp_17th_accepted", p_idx, 17);
        for (int i = 0; i < 40; i++) prod(m_phase == 7);

        // Two sets from 14 buffered points, second gf_valid after a long wait.
        reset_dut();
        p_base = 600; p_idx = 0; p_total = 14; done_seen = 0;
        for (int i = 0; i < 16; i++) prod(1'b0);
        prod(1'b1);
        check("two_set1_X", int'(X), 600);
        for (int i = 0; i < 7; i++) prod(1'b0);
        for (int i = 0; i < 19; i++) prod(1'b0);
        prod(1'b1);
        check("two_set2_X", int'(X), 607);
        for (int i = 0; i < 7; i++) prod(1'b0);
        check("two_done_pulses", done_seen, 2);
        prod(1'b1);
        check("two_fifo_empty_X", int'(X), 0);
        for (int i = 0; i < 7; i++) prod(1'b0);

        // Reset asserted in SEND(4) of a committed window.
        p_base = 700; p_idx = 0; p_total = 7;
        for (int i = 0; i < 7; i++) prod(1'b0);
        prod(1'b1);
        for (int i = 0; i < 4; i++) prod(1'b0);
        check("mid_send4_X", int'(X), 704);
        reset = 1'b1;
        #1;
        check("mid_rst_X", int'(X), 0);
        check("mid_rst_Y", int'(Y), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_under", int'(underrun), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        p_idx = 0; p_total = 0;
        for (int i = 0; i < 9; i++) prod(1'b0);
        check("mid_after_underrun", int'(underrun), 1);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            pt_t p;
            bit  acc;
            p.x = 10'($urandom_range(0, 1023));
            p.y = 10'($urandom_range(0, 1023));
            cycle(($urandom % 3) != 0, p, ($urandom % 6) == 0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
